// File: rtl/seq_mult.sv
// Sequential shift-and-add multiplier: WIDTH-bit operands, signed or unsigned,
// one partial product per clock, start/busy/done handshake.
module seq_mult #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [2*WIDTH:0]      acc_q, acc_d;
  logic [WIDTH-1:0]      mcand_q, mcand_d;
  logic [WIDTH-1:0]      mplier_q, mplier_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  neg_q, neg_d;
  logic [2*WIDTH-1:0]    product_q, product_d;

  logic [WIDTH-1:0]      a_mag, b_mag;
  logic [WIDTH:0]        upper_sum;
  logic [2*WIDTH:0]      acc_shift;

  // Magnitudes as unsigned WIDTH-bit values; -2^(WIDTH-1) maps to 2^(WIDTH-1).
  always_comb begin
    a_mag = (signed_mode && a[WIDTH-1]) ? (~a + 1'b1) : a;
    b_mag = (signed_mode && b[WIDTH-1]) ? (~b + 1'b1) : b;
  end

  always_comb begin
    upper_sum = acc_q[2*WIDTH:WIDTH] + {1'b0, (mplier_q[0] ? mcand_q : '0)};
    acc_shift = {1'b0, upper_sum, acc_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    count_d   = count_q;
    neg_d     = neg_q;
    product_d = product_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mcand_d  = a_mag;
          mplier_d = b_mag;
          neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d    = '0;
          count_d  = COUNT_INIT;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        acc_d    = acc_shift;
        mplier_d = mplier_q >> 1;
        count_d  = count_q - 1'b1;
        // Last partial product: publish the result on the same edge that enters DONE.
        if (count_q == CW'(1)) begin
          state_d   = DONE;
          product_d = neg_q ? (~acc_shift[2*WIDTH-1:0] + 1'b1) : acc_shift[2*WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      count_q   <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      count_q   <= count_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule
